// File: rtl/e_register.sv
// WIDTH-bit register with parallel load and right shift. The serial output is R[0].
// The parallel output is R[WIDTH-1:1]. The reset is asynchronous and active-low.
module e_register #(
  parameter int WIDTH = 8
) (
  output logic             ops,
  output logic [WIDTH-2:0] Q,
  input  logic             lds,
  input  logic [WIDTH-1:0] L,
  input  logic             clk,
  input  logic             sis,
  input  logic             ebl,
  input  logic             rst_n
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_next;

  // Load wins over shift, and neither happens unless enabled.
  always_comb begin
    w_next = r_data;
    if (ebl) begin
      if (lds) begin
        w_next = L;
      end else begin
        w_next = {sis, r_data[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else begin
      r_data <= w_next;
    end
  end

  assign ops = r_data[0];
  assign Q   = r_data[WIDTH-1:1];

endmodule

// File: tb/tb_e_register.sv
// Directed self-checking bench for e_register (WIDTH=8).
// It compares the concatenation {Q, ops} against hand-computed register values.
module tb_e_register;

  logic       clk;
  logic       rst_n;
  logic       ops;
  logic [6:0] Q;
  logic       lds;
  logic [7:0] L;
  logic       sis;
  logic       ebl;

  int testsRun;
  int testsFailed;

  e_register #(.WIDTH(8)) dut (
    .ops   (ops),
    .Q     (Q),
    .lds   (lds),
    .L     (L),
    .clk   (clk),
    .sis   (sis),
    .ebl   (ebl),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ldsV, input logic [7:0] lV,
                               input logic sisV, input logic eblV);
    lds = ldsV;
    L   = lV;
    sis = sisV;
    ebl = eblV;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expR);
    testsRun++;
    assert ({Q, ops} === expR) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed R=%h (Q=%b ops=%b), expected R=%h", tag, {Q, ops}, Q, ops, expR);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
    #2;
    checkOutput("reset_initial", 8'h00);
    tick();
    checkOutput("reset_held_edge1", 8'h00);
    tick();
    checkOutput("reset_held_edge2", 8'h00);

    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'b10011101, 1'b0, 1'b1);
    tick();
    checkOutput("load_9D", 8'h9D);
    testsRun++;
    assert (ops === 1'b1 && Q === 7'b1001110) else begin
      testsFailed++;
      $error("[TB] FAIL load_fields: observed ops=%b Q=%b, expected ops=1 Q=1001110", ops, Q);
    end

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("shift0_edge1", 8'h4E);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("shift0_edge7", 8'h01);

    applyStimulus(1'b1, 8'h9D, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("hold_load_edge%0d", i + 1), 8'h01);
    end
    applyStimulus(1'b0, 8'h9D, 1'b1, 1'b0);
    tick();
    checkOutput("hold_shift", 8'h01);

    applyStimulus(1'b1, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("load_zero_priority", 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("shift1_edge1", 8'h80);
    tick();
    checkOutput("shift1_edge2", 8'hC0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("shift1_edge7", 8'hFE);
    tick();
    checkOutput("shift1_edge8", 8'hFF);

    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1);
    tick();
    checkOutput("load_A5", 8'hA5);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("shift_A5", 8'h52);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("shift_52_sis1", 8'hA9);

    applyStimulus(1'b1, 8'h9D, 1'b0, 1'b1);
    tick();
    checkOutput("preload_9D", 8'h9D);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("shift_before_reset", 8'hCE);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_midcycle", 8'h00);
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
    tick();
    checkOutput("reset_low_edge1", 8'h00);
    tick();
    checkOutput("reset_low_edge2", 8'h00);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("first_edge_after_reset", 8'h80);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
